// File: rtl/vga_pkg.sv
// Shared timing constants, colour type and tile helper
// for the 640x480 tile display.
package vga_pkg;

  typedef logic [11:0] rgb_t;

  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_SYNC_END   = 751;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_SYNC_END   = 491;

  localparam logic [5:0] TILE_BLANK = 6'h3F;

  localparam rgb_t RGB_WHITE = 12'hFFF;
  localparam rgb_t RGB_BLUE  = 12'h00F;
  localparam rgb_t RGB_BLACK = 12'h000;

  // Outside the visible span the tile index is 63,
  // which no sprite position can match.
  function automatic logic [5:0] tile_of(
    input logic [9:0]  pos,
    input int unsigned lim,
    input int unsigned shift
  );
    if (32'(pos) < lim) return 6'(pos >> shift);
    return TILE_BLANK;
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Clock-enable divider: one-clk tick every DIV clocks.
// The tick is high while the count sits at DIV-1.
module vga_pixel_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = $clog2(DIV);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/vga_tile_timing.sv
// VGA timing, tile coordinates and registered RGB stage.
// Sync and colour leave one pixel tick after the counters.
module vga_tile_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned TILE_SHIFT = 4,
  parameter rgb_t        FG_RGB     = RGB_WHITE,
  parameter rgb_t        BORDER_RGB = RGB_BLUE,
  parameter rgb_t        BG_RGB     = RGB_BLACK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       draw_fg,
  output logic [5:0] counter_x,
  output logic [5:0] counter_y,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS0 = H_ACTIVE + H_FP;
  localparam int unsigned HS1 = HS0 + H_SYNC;
  localparam int unsigned VS0 = V_ACTIVE + V_FP;
  localparam int unsigned VS1 = VS0 + V_SYNC;

  localparam logic [5:0] COL_LAST =
    6'((H_ACTIVE >> TILE_SHIFT) - 1);
  localparam logic [5:0] ROW_LAST =
    6'((V_ACTIVE >> TILE_SHIFT) - 1);

  logic tick;

  vga_pixel_tick #(.DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [9:0] nx, ny;
  logic       wrap_x, wrap_y;

  always_comb begin
    wrap_x = (pix_x == 10'(HT - 1));
    wrap_y = (pix_y == 10'(VT - 1));
    nx     = wrap_x ? '0 : pix_x + 1'b1;
    ny     = pix_y;
    if (wrap_x) ny = wrap_y ? '0 : pix_y + 1'b1;
  end

  logic active, border, hs_win, vs_win;

  assign active = (counter_x != TILE_BLANK) &&
                  (counter_y != TILE_BLANK);
  assign border = (counter_x == '0) ||
                  (counter_x == COL_LAST) ||
                  (counter_y == '0) ||
                  (counter_y == ROW_LAST);
  assign hs_win = (pix_x >= 10'(HS0)) &&
                  (pix_x <  10'(HS1));
  assign vs_win = (pix_y >= 10'(VS0)) &&
                  (pix_y <  10'(VS1));

  rgb_t rgb, rgb_next;

  always_comb begin
    rgb_next = '0;
    unique case (1'b1)
      !active:                     rgb_next = '0;
      active && draw_fg:           rgb_next = FG_RGB;
      active && !draw_fg && border: rgb_next = BORDER_RGB;
      default:                     rgb_next = BG_RGB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_x      <= '0;
      pix_y      <= '0;
      counter_x  <= '0;
      counter_y  <= '0;
      frame_tick <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb        <= '0;
    end else begin
      frame_tick <= tick && wrap_x && wrap_y;
      if (tick) begin
        pix_x     <= nx;
        pix_y     <= ny;
        counter_x <= tile_of(nx, H_ACTIVE, TILE_SHIFT);
        counter_y <= tile_of(ny, V_ACTIVE, TILE_SHIFT);
        hsync     <= ~hs_win;
        vsync     <= ~vs_win;
        rgb       <= rgb_next;
      end
    end
  end

  assign {red, green, blue} = rgb;

endmodule

// File: tb/tb_vga_tile_timing.sv
// Bench for vga_tile_timing: three geometries checked against
// an arithmetic pixel-index model with an RGB/sync scoreboard.
module tb_vga_tile_timing;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   run = 1'b0;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  // dut0: full timing /4, dut1: full timing /2, dut2: small frame /2
  localparam int D_T [3]  = '{4, 2, 2};
  localparam int HA_T [3] = '{640, 640, 96};
  localparam int HF_T [3] = '{16, 16, 4};
  localparam int HS_T [3] = '{96, 96, 8};
  localparam int HB_T [3] = '{48, 48, 4};
  localparam int VA_T [3] = '{480, 480, 64};
  localparam int VF_T [3] = '{10, 10, 2};
  localparam int VS_T [3] = '{2, 2, 2};
  localparam int VB_T [3] = '{33, 33, 3};
  localparam int BX_T [3] = '{20, 20, 2};
  localparam int BY_T [3] = '{0, 1, 1};

  task automatic chk(input string nm, input int g,
                     input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s dut%0d t=%0t got %0h want %0h",
               nm, g, $time, act, exp);
    end
  endtask

  function automatic int tile(input int p, input int lim);
    return (p < lim) ? p / 16 : 63;
  endfunction

  function automatic exp_t model(
    input int px, input int py,
    input int ha, input int hf, input int hs,
    input int va, input int vf, input int vs,
    input bit fg
  );
    exp_t r;
    int tx, ty;
    r.hs  = !(px >= ha + hf && px < ha + hf + hs);
    r.vs  = !(py >= va + vf && py < va + vf + vs);
    r.rgb = 12'h000;
    if (px < ha && py < va) begin
      tx = px / 16;
      ty = py / 16;
      if (fg)
        r.rgb = 12'hFFF;
      else if (tx == 0 || tx == ha / 16 - 1 ||
               ty == 0 || ty == va / 16 - 1)
        r.rgb = 12'h00F;
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D  = D_T[g];
    localparam int HA = HA_T[g];
    localparam int HF = HF_T[g];
    localparam int HS = HS_T[g];
    localparam int HB = HB_T[g];
    localparam int VA = VA_T[g];
    localparam int VF = VF_T[g];
    localparam int VS = VS_T[g];
    localparam int VB = VB_T[g];
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic       draw_fg;
    logic [5:0] counter_x, counter_y;
    logic [9:0] pix_x, pix_y;
    logic       frame_tick, hsync, vsync;
    logic [3:0] red, green, blue;

    vga_tile_timing #(
      .CLK_DIV  (D),
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .draw_fg    (draw_fg),
      .counter_x  (counter_x),
      .counter_y  (counter_y),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .frame_tick (frame_tick),
      .hsync      (hsync),
      .vsync      (vsync),
      .red        (red),
      .green      (green),
      .blue       (blue)
    );

    int   e = 0;
    exp_t q[$];

    always @(posedge clk)
      if (run) e <= e + 1;

    // Sprite plus random noise, driven one clk after the
    // counters move to pixel k; the expected pixel is queued.
    initial begin
      int  k, px, py;
      bit  hit, fg;
      draw_fg = 1'b0;
      forever begin
        @(negedge clk);
        if (run && e % D == 1) begin
          k   = e / D;
          px  = k % HT;
          py  = (k / HT) % VT;
          hit = px < HA && py < VA &&
                px / 16 == BX_T[g] && py / 16 == BY_T[g];
          fg  = hit || ($urandom_range(0, 3) == 0);
          draw_fg = fg;
          q.push_back(model(px, py, HA, HF, HS, VA, VF, VS, fg));
        end
      end
    end

    initial begin
      int   k, px, py;
      bit   ft;
      exp_t cur;
      int   last_hf, last_vf, last_ft;
      logic prev_hs, prev_vs;
      cur     = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
      last_hf = -1;
      last_vf = -1;
      last_ft = -1;
      prev_hs = 1'b1;
      prev_vs = 1'b1;
      forever begin
        @(negedge clk);
        if (run) begin
          k  = e / D;
          px = k % HT;
          py = (k / HT) % VT;
          ft = (e % D == 0) && k > 0 && (k % FR == 0);
          chk("pix_x", g, pix_x, px);
          chk("pix_y", g, pix_y, py);
          chk("counter_x", g, counter_x, tile(px, HA));
          chk("counter_y", g, counter_y, tile(py, VA));
          chk("frame_tick", g, frame_tick, ft);
          if (e % D == 0 && k > 0) begin
            chk("sb_depth", g, q.size(), 1);
            if (q.size() > 0) cur = q.pop_front();
          end
          chk("rgb", g, {red, green, blue}, cur.rgb);
          chk("hsync", g, hsync, cur.hs);
          chk("vsync", g, vsync, cur.vs);
          if (prev_hs && !hsync) begin
            if (last_hf >= 0)
              chk("hsync_period", g, e - last_hf, HT * D);
            last_hf = e;
          end
          if (!prev_hs && hsync && last_hf >= 0)
            chk("hsync_low", g, e - last_hf, HS * D);
          if (prev_vs && !vsync) begin
            chk("vsync_start", g, e % (FR * D),
                D * ((VA + VF) * HT + 1));
            last_vf = e;
          end
          if (!prev_vs && vsync && last_vf >= 0)
            chk("vsync_low", g, e - last_vf, VS * HT * D);
          if (frame_tick) begin
            if (last_ft >= 0)
              chk("frame_period", g, e - last_ft, FR * D);
            last_ft = e;
          end
          prev_hs = hsync;
          prev_vs = vsync;
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (n < 5000 && g_dut[0].pix_x != 10'd300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pix300", 0, g_dut[0].pix_x, 300);
    chk("pre_reset_rgb", 0,
        {g_dut[0].red, g_dut[0].green, g_dut[0].blue}, 12'h00F);
    #2 rst = 1'b0;
    #1;
    chk("rst_pix_x", 0, g_dut[0].pix_x, 0);
    chk("rst_pix_y", 0, g_dut[0].pix_y, 0);
    chk("rst_counter_x", 0, g_dut[0].counter_x, 0);
    chk("rst_counter_y", 0, g_dut[0].counter_y, 0);
    chk("rst_hsync", 0, g_dut[0].hsync, 1);
    chk("rst_vsync", 0, g_dut[0].vsync, 1);
    chk("rst_frame_tick", 0, g_dut[0].frame_tick, 0);
    chk("rst_rgb", 0,
        {g_dut[0].red, g_dut[0].green, g_dut[0].blue}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    repeat (42000) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vga_tile_timing.md
Name: vga_tile_timing

Overview:
VGA 640x480@60 timing generator and pixel output stage for the tile-based game display. Produces hsync/vsync and pixel counters, and derives 6-bit tile coordinates (16x16 px tiles, 40x30 grid) that feed sprite blocks such as the ball. Samples the sprites' one-clock-registered draw flag and drives 12-bit RGB, aligned with sync. Also emits a per-frame tick for game-logic pacing.

Parameters:
CLK_DIV, 4, system clocks per pixel; legal range 2..16 (100 MHz -> 25 MHz pixel)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
TILE_SHIFT, 4, log2 tile size in pixels
FG_RGB, 12'hFFF, colour when draw_fg is set
BORDER_RGB, 12'h00F, colour of the outer tile ring
BG_RGB, 12'h000, active-area background colour

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
draw_fg  input  1  OR of sprite draw flags; registered by sprites one clk after counter change
counter_x  output  6  tile column, 0..39 active, 63 in blanking
counter_y  output  6  tile row, 0..29 active, 63 in blanking
pix_x  output  10  horizontal pixel counter, 0..799
pix_y  output  10  vertical line counter, 0..524
frame_tick  output  1  one-clk pulse at start of each frame
hsync  output  1  active-low horizontal sync
vsync  output  1  active-low vertical sync
red  output  4  pixel red
green  output  4  pixel green
blue  output  4  pixel blue

Behaviour:
- Timing: Clock-enable divider counts 0..CLK_DIV-1. Pixel tick asserts on the clk where the divider equals CLK_DIV-1.
- Counter reset values: rst low (async) clears divider, pix_x, pix_y, counter_x and counter_y to 0.
- Output reset values: hsync=1, vsync=1, RGB=0, frame_tick=0.
- pix_x: On each tick, pix_x increments; at 799 it wraps to 0 and pix_y increments; pix_y wraps 524 -> 0.
- Tile coordinates: counter_x/counter_y are registered on the same tick as pix_x/pix_y, from the next pixel values.
- Tile mapping: counter_x = next_pix_x >> TILE_SHIFT when next_pix_x < H_ACTIVE, else 6'h3F; counter_y is the same for y vs V_ACTIVE. A blanking value of 63 never matches any sprite.
- frame_tick: high for exactly one clk, on the tick where pix_x/pix_y wrap to (0,0).
- Sync and active pipeline: hsync, vsync and the active flag pass through one pixel-tick pipeline stage so they align with RGB.
- Sync windows (raw counter values): hsync low for pix_x 656..751; vsync low for pix_y 490..491.
- RGB latency: RGB is registered on the tick after the counters show pixel P, and holds P's colour. draw_fg is sampled on that tick; CLK_DIV>=2 guarantees the sprite's registered flag is valid by then.
- Colour priority (active pixels): draw_fg -> FG_RGB; else tile column 0 or 39, or tile row 0 or 29 -> BORDER_RGB; else BG_RGB.
- Blanking: RGB=0 regardless of draw_fg.
- Divider boundary: changing CLK_DIV needs no other change; all counts are in pixel ticks.
- Reset mid-frame: outputs return to reset values immediately. After release, the first tick occurs CLK_DIV clks later.

Decomposition:
- Package vga_pkg: timing constants (H_TOTAL=800, V_TOTAL=525, sync start/end), TILE_BLANK=6'h3F, 12-bit rgb_t, colour constants.
- Sub-module vga_pixel_tick: parameterised clock-enable divider with async active-low reset, output tick.

Test Plan:
1. Reset: rst low while pix_x=300 -> all outputs at reset values in the same clk. Release -> first tick after 4 clks; pix_x=1.
2. Line timing (CLK_DIV=4): hsync falling edges 3200 clks apart; hsync low for 384 clks. RGB for pix_x=655 is still driven before the first low sync sample.
3. Frame timing: frame_tick period 1,680,000 clks. vsync low 6400 clks, starting on line 490 (delayed one tick).
4. Tile mapping: pix_x=175 -> counter_x=10; 640..799 -> 63. pix_y=479 -> counter_y=29; 480 -> 63.
5. Colour: bench model of a ball sprite at tile (20,15) raises draw_fg -> RGB=FFF one tick later on those pixels. Tile (0,5) -> 00F. Tile (10,10) -> 000. draw_fg=1 during blanking -> RGB=0.
6. CLK_DIV=2 rerun of scenarios 2 and 5 -> hsync spacing 1600 clks; colour alignment unchanged.
